event_toggle_tx: RTL and testbench

- Source-domain front end of the toggle CDC path.
- Accepts single-cycle event strobes and queues them in a saturating pending counter.
- Launches one event at a time by flipping o_toggle, then waits for the destination's ack toggle to match before launching the next. The destination returns the ack via sync_ff into this domain.
- Guarantees the destination's toggle-to-strobe stage never sees two flips merged into one, so no events are lost silently.

---
 rtl/cdc_pkg.sv | 10 +
 rtl/event_toggle_tx.sv | 111 +++++++++++
 tb/tb_event_toggle_tx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle-based CDC event path.
// Holds the FSM state encoding and the default pending-counter width.
package cdc_pkg;

   localparam logic ST_IDLE     = 1'b0;
   localparam logic ST_WAIT_ACK = 1'b1;

   localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/event_toggle_tx.sv
// Source-domain front end of the toggle CDC path: queues event strobes
// in a saturating counter and launches them one at a time as toggles.
// Ports:
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   i_event           one event per high cycle
//   i_ack_toggle      destination ack toggle, already synchronized
//   i_clr_overflow    clears the sticky overflow flag
//   o_toggle          registered event toggle to destination
//   o_busy            high while an event is in flight
//   o_pending         events accepted but not yet launched
//   o_overflow        sticky, an event was dropped on a full counter
module event_toggle_tx
   import cdc_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_event,
   input  logic             i_ack_toggle,
   input  logic             i_clr_overflow,
   output logic             o_toggle,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_pending,
   output logic             o_overflow
);

   logic             state_q, state_d;
   logic             toggle_q, toggle_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             ovf_q, ovf_d;

   logic pend_nz;
   logic pend_full;
   logic launch;
   logic take;
   logic dec;
   logic ovf_set;

   assign pend_nz   = |pend_q;
   assign pend_full = &pend_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         toggle_q <= 1'b0;
         pend_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         toggle_q <= toggle_d;
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      toggle_d = toggle_q;
      pend_d   = pend_q;
      ovf_d    = ovf_q;
      launch   = 1'b0;
      take     = 1'b0;
      dec      = 1'b0;
      ovf_set  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pend_nz || i_event) begin
               launch   = 1'b1;
               toggle_d = ~toggle_q;
               state_d  = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            // The ack cycle itself never launches.
            if (i_ack_toggle == toggle_q) begin
               state_d = ST_IDLE;
            end
         end
      endcase

      // A launch from an empty queue consumes the incoming
      // event directly, so that event is never counted.
      take = i_event && !(launch && !pend_nz);
      dec  = launch && pend_nz;

      if (take && !dec) begin
         if (pend_full) begin
            ovf_set = 1'b1;
         end else begin
            pend_d = pend_q + CNT_W'(1);
         end
      end else if (!take && dec) begin
         pend_d = pend_q - CNT_W'(1);
      end

      // A fresh overflow wins over a same-cycle clear.
      if (ovf_set) begin
         ovf_d = 1'b1;
      end else if (i_clr_overflow) begin
         ovf_d = 1'b0;
      end
   end

   assign o_toggle   = toggle_q;
   assign o_busy     = (state_q == ST_WAIT_ACK);
   assign o_pending  = pend_q;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_event_toggle_tx.sv
// Directed bench for event_toggle_tx: a wide instance (CNT_W=4)
// and a narrow one (CNT_W=2) for saturation and overflow corners.
module tb_event_toggle_tx;

   logic clk;
   logic rst_n;

   logic       ev_a, ack_a, clr_a;
   logic       tog_a, busy_a, ovf_a;
   logic [3:0] pend_a;

   logic       ev_b, ack_b, clr_b;
   logic       tog_b, busy_b, ovf_b;
   logic [1:0] pend_b;

   int checks;
   int passes;

   event_toggle_tx #(.CNT_W(4)) u_dut_a (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_event        (ev_a),
      .i_ack_toggle   (ack_a),
      .i_clr_overflow (clr_a),
      .o_toggle       (tog_a),
      .o_busy         (busy_a),
      .o_pending      (pend_a),
      .o_overflow     (ovf_a)
   );

   event_toggle_tx #(.CNT_W(2)) u_dut_b (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_event        (ev_b),
      .i_ack_toggle   (ack_b),
      .i_clr_overflow (clr_b),
      .o_toggle       (tog_b),
      .o_busy         (busy_b),
      .o_pending      (pend_b),
      .o_overflow     (ovf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic       ev;
      logic       ack;
      logic       clr;
      logic       tog;
      logic       busy;
      logic [3:0] pend;
      logic       ovf;
   } vec_t;

   vec_t tbl [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name,
                        input int got,
                        input int exp);
      checks++;
      if (got == exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0d expected %0d",
                  name, got, exp);
      end
   endtask

   initial begin
      int   flips;
      int   maxp;
      logic prev;
      logic hist [$];

      checks = 0;
      passes = 0;

      // reset rows, then single event with ack after 3 cycles
      tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};

      ev_b  = 1'b0;
      ack_b = 1'b0;
      clr_b = 1'b0;

      for (int i = 0; i < 8; i++) begin
         rst_n = tbl[i].rst_n;
         ev_a  = tbl[i].ev;
         ack_a = tbl[i].ack;
         clr_a = tbl[i].clr;
         tick();
         check($sformatf("row%0d toggle", i),
               int'(tog_a), int'(tbl[i].tog));
         check($sformatf("row%0d busy", i),
               int'(busy_a), int'(tbl[i].busy));
         check($sformatf("row%0d pending", i),
               int'(pend_a), int'(tbl[i].pend));
         check($sformatf("row%0d overflow", i),
               int'(ovf_a), int'(tbl[i].ovf));
      end

      // burst of 5 with ack looped back 3 cycles late
      flips = 0;
      maxp  = 0;
      prev  = tog_a;
      for (int i = 0; i < 80; i++) begin
         ev_a = (i < 5);
         tick();
         if (tog_a != prev) flips++;
         prev = tog_a;
         if (int'(pend_a) > maxp) maxp = int'(pend_a);
         hist.push_back(tog_a);
         if (hist.size() >= 4) ack_a = hist[hist.size()-4];
      end
      ev_a = 1'b0;
      check("burst flips", flips, 5);
      check("burst peak pending", maxp, 4);
      check("burst final pending", int'(pend_a), 0);
      check("burst overflow", int'(ovf_a), 0);
      check("burst busy", int'(busy_a), 0);

      // narrow counter: ack held off, 5 events
      flips = 0;
      prev  = tog_b;
      ack_b = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ev_b = 1'b1;
         tick();
         if (tog_b != prev) flips++;
         prev = tog_b;
      end
      check("sat pending", int'(pend_b), 3);
      check("sat overflow", int'(ovf_b), 1);
      check("sat busy", int'(busy_b), 1);
      check("sat launched", flips, 1);

      // new overflow and clear in the same cycle
      ev_b  = 1'b1;
      clr_b = 1'b1;
      tick();
      check("ovf set beats clr", int'(ovf_b), 1);
      ev_b = 1'b0;
      tick();
      check("ovf clr alone", int'(ovf_b), 0);
      clr_b = 1'b0;

      // release ack with immediate loopback
      for (int i = 0; i < 40; i++) begin
         ack_b = tog_b;
         tick();
         if (tog_b != prev) flips++;
         prev = tog_b;
      end
      check("sat total flips", flips, 4);
      check("sat drained", int'(pend_b), 0);

      // mid-flight reset with two queued events
      for (int i = 0; i < 3; i++) begin
         ev_a = 1'b1;
         tick();
      end
      ev_a = 1'b0;
      check("pre-rst busy", int'(busy_a), 1);
      check("pre-rst pending", int'(pend_a), 2);
      check("pre-rst toggle", int'(tog_a), 1);
      rst_n = 1'b0;
      tick();
      check("rst toggle", int'(tog_a), 0);
      check("rst pending", int'(pend_a), 0);
      check("rst busy", int'(busy_a), 0);
      rst_n = 1'b1;
      flips = 0;
      prev  = tog_a;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (tog_a != prev) flips++;
         prev = tog_a;
      end
      check("post-rst flips", flips, 0);
      check("post-rst busy", int'(busy_a), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
